// File: rtl/onfi_status_poll_pkg.sv
// ----------------------------------------------------------------------------
// onfi_pkg
// Shared definitions for the ONFI command stages:
//   - state_e          : status-poll state machine encoding
//   - CMD_READ_STATUS  : Read Status opcode (70h)
//   - SR_RDY_BIT       : RDY bit position in the status register
//   - pins_t/PINS_IDLE : pin-side control bundle and its idle value
//   - max3()           : helper for sizing shared wait counters
// ----------------------------------------------------------------------------
package onfi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_HOLD,
        ST_WHR,
        ST_READ,
        ST_CHECK,
        ST_GAP
    } state_e;

    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam int         SR_RDY_BIT      = 6;

    typedef struct packed {
        logic        cen;
        logic        cle;
        logic        ale;
        logic        wen;
        logic        dqs_en;
        logic        dq_en;
        logic [31:0] dq_o;
    } pins_t;

    // CE# and WE# are active low, so idle means both high; everything else low.
    localparam pins_t PINS_IDLE = '{
        cen:    1'b1,
        cle:    1'b0,
        ale:    1'b0,
        wen:    1'b1,
        dqs_en: 1'b0,
        dq_en:  1'b0,
        dq_o:   32'h0
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/onfi_status_poll_if.sv
// ----------------------------------------------------------------------------
// onfi_status_poll_if
// Control handshake and ONFI pin bundle of the status-poll stage.
//   start/busy/done/timeout/status : request side
//   onfi_dq_i                      : DQ input (bits [7:0] carry the status)
//   onfi_cen/cle/ale/wen/dqs_en    : pin controls
//   onfi_dq_o/onfi_dq_en           : DQ output value and enable
// modport master : the poll stage (drives pins and status)
// modport slave  : the requester / pin model
// ----------------------------------------------------------------------------
interface onfi_status_poll_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  status;
    logic [31:0] onfi_dq_i;
    logic        onfi_cen;
    logic        onfi_cle;
    logic        onfi_ale;
    logic        onfi_wen;
    logic        onfi_dqs_en;
    logic [31:0] onfi_dq_o;
    logic        onfi_dq_en;

    modport master (
        input  start, onfi_dq_i,
        output busy, done, timeout, status,
               onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dqs_en,
               onfi_dq_o, onfi_dq_en
    );

    modport slave (
        output start, onfi_dq_i,
        input  busy, done, timeout, status,
               onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dqs_en,
               onfi_dq_o, onfi_dq_en
    );
endinterface

// File: rtl/onfi_status_poll_wait_cnt.sv
// ----------------------------------------------------------------------------
// onfi_wait_cnt
// Loadable down-counter with a zero flag, clocked on the falling edge.
// Loading N-1 makes the owning state last exactly N edges.
//   clk_i   : controller clock (falling edge active)
//   rst_ni  : asynchronous active-low reset
//   load_i  : load val_i (takes priority over counting)
//   val_i   : load value
//   zero_o  : counter is at zero
// ----------------------------------------------------------------------------
module onfi_wait_cnt #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/onfi_status_poll.sv
// ----------------------------------------------------------------------------
// onfi_status_poll
// Read-Status polling stage: issues 70h, waits tWHR, samples DQ[7:0] and
// repeats until SR[6] (RDY) is set. All state updates on the falling edge.
// Ports:
//   onfi_clk    : controller clock
//   onfi_rst_n  : asynchronous active-low reset
//   bus         : onfi_status_poll_if.master (start/busy/done/timeout/status
//                 plus ONFI pin controls and DQ)
// Parameters: WHR_CYCLES, READ_LAT, POLL_GAP, MAX_POLLS.
// Build option: ONFI_POLL_TIMEOUT_EN adds a poll counter that pulses
// `timeout` after MAX_POLLS failed polls; without it polling never gives up
// and `timeout` is constant 0.
// ----------------------------------------------------------------------------
module onfi_status_poll
    import onfi_pkg::*;
#(
    parameter int WHR_CYCLES = 8,
    parameter int READ_LAT   = 2,
    parameter int POLL_GAP   = 4,
    parameter int MAX_POLLS  = 1024
) (
    input  logic                onfi_clk,
    input  logic                onfi_rst_n,
    onfi_status_poll_if.master  bus
);
    localparam int WAIT_MAX = max3(WHR_CYCLES, READ_LAT, POLL_GAP);
    localparam int CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

    state_e      state_q;
    pins_t       pins_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic [7:0]  status_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             tmo_hit;

    // Only the low status byte is meaningful on DQ.
    logic [23:0] unused_dq;
    assign unused_dq = bus.onfi_dq_i[31:8];

    // One counter serves WHR, READ and GAP; it is loaded on the edge that
    // enters each of those states.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_HOLD: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(WHR_CYCLES - 1);
            end
            ST_WHR: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(READ_LAT - 1);
            end
            ST_CHECK: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(POLL_GAP - 1);
            end
            default: ;
        endcase
    end

    onfi_wait_cnt #(.W(CNT_W)) u_wait (
        .clk_i  (onfi_clk),
        .rst_ni (onfi_rst_n),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .zero_o (cnt_zero)
    );

`ifdef ONFI_POLL_TIMEOUT_EN
    localparam int PC_W = $clog2(MAX_POLLS + 1);

    logic [PC_W-1:0] poll_cnt_q;
    logic [PC_W-1:0] poll_cnt_d;

    // Saturating count of failed polls, cleared when a request is accepted.
    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (state_q == ST_IDLE && bus.start)
            poll_cnt_d = '0;
        else if (state_q == ST_CHECK && !status_q[SR_RDY_BIT] && poll_cnt_q != '1)
            poll_cnt_d = poll_cnt_q + 1'b1;
    end

    always_ff @(negedge onfi_clk or negedge onfi_rst_n) begin
        if (!onfi_rst_n) poll_cnt_q <= '0;
        else             poll_cnt_q <= poll_cnt_d;
    end

    // Compared against the incremented value, so the MAX_POLLS-th failure fires.
    assign tmo_hit = (poll_cnt_d == PC_W'(MAX_POLLS));
`else
    logic [31:0] unused_max_polls;
    assign unused_max_polls = 32'(MAX_POLLS);
    assign tmo_hit          = 1'b0;
`endif

    always_ff @(negedge onfi_clk or negedge onfi_rst_n) begin
        if (!onfi_rst_n) begin
            state_q   <= ST_IDLE;
            pins_q    <= PINS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            status_q  <= 8'h00;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    pins_q.cen <= 1'b0;
                    pins_q.cle <= 1'b0;
                    pins_q.wen <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= ST_LATCH;
                end
                ST_LATCH: begin
                    pins_q.cle   <= 1'b1;
                    pins_q.dq_o  <= 32'(CMD_READ_STATUS);
                    pins_q.dq_en <= 1'b1;
                    state_q      <= ST_HOLD;
                end
                ST_HOLD: begin
                    // WE# low here selects the read direction for the data phase.
                    pins_q.cle   <= 1'b0;
                    pins_q.dq_en <= 1'b0;
                    pins_q.wen   <= 1'b0;
                    state_q      <= ST_WHR;
                end
                ST_WHR: if (cnt_zero) begin
                    state_q <= ST_READ;
                end
                ST_READ: if (cnt_zero) begin
                    status_q <= bus.onfi_dq_i[7:0];
                    state_q  <= ST_CHECK;
                end
                ST_CHECK: begin
                    pins_q.wen <= 1'b1;
                    pins_q.cen <= 1'b1;
                    if (status_q[SR_RDY_BIT]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: if (cnt_zero) begin
                    pins_q.cen <= 1'b0;
                    state_q    <= ST_LATCH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.status      = status_q;
    assign bus.onfi_cen    = pins_q.cen;
    assign bus.onfi_cle    = pins_q.cle;
    assign bus.onfi_ale    = pins_q.ale;
    assign bus.onfi_wen    = pins_q.wen;
    assign bus.onfi_dqs_en = pins_q.dqs_en;
    assign bus.onfi_dq_o   = pins_q.dq_o;
    assign bus.onfi_dq_en  = pins_q.dq_en;
endmodule

// File: tb/tb_onfi_status_poll.sv
// ----------------------------------------------------------------------------
// tb_onfi_status_poll
// Scoreboard bench for onfi_status_poll (WHR=8, READ_LAT=2, GAP=4,
// MAX_POLLS=3). Stimulus pushes the expected pin/handshake events with their
// edge numbers (relative to the accepting edge E0); a monitor turns observed
// CE# fall, CLE high, CE# rise, done and timeout into events and compares.
// Expectations for the last scenario depend on ONFI_POLL_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_onfi_status_poll;
    localparam int EV_CENLO = 0;
    localparam int EV_CLE   = 1;
    localparam int EV_CENHI = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_TMO   = 4;

    typedef struct {
        int          kind;
        int          edge_no;
        logic [39:0] data;
    } ev_t;

    // busy,done,timeout,status,cen,cle,ale,wen,dqs_en,dq_en,dq_o
    localparam logic [48:0] RST_OUTS = {3'b000, 8'h00, 6'b100100, 32'h0};
    localparam logic [39:0] CLE_DATA = {7'b0, 1'b1, 32'h70};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   ecnt   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_cen = 1'b1;
    ev_t  exp_q[$];

    onfi_status_poll_if bus();

    onfi_status_poll #(
        .WHR_CYCLES (8),
        .READ_LAT   (2),
        .POLL_GAP   (4),
        .MAX_POLLS  (3)
    ) dut (
        .onfi_clk   (clk),
        .onfi_rst_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) ecnt <= ecnt + 1;

    function automatic logic [48:0] outs();
        return {bus.busy, bus.done, bus.timeout, bus.status,
                bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen,
                bus.onfi_dqs_en, bus.onfi_dq_en, bus.onfi_dq_o};
    endfunction

    function automatic void exp_ev(input int kind, input int e, input logic [39:0] d);
        ev_t ev;
        ev.kind    = kind;
        ev.edge_no = e;
        ev.data    = d;
        exp_q.push_back(ev);
    endfunction

    // One Read Status poll p starting from E0=b: CE# low, CLE/70h, CE# high.
    function automatic void exp_poll(input int b, input int p);
        exp_ev(EV_CENLO, b + 17*p,      40'h0);
        exp_ev(EV_CLE,   b + 17*p + 1,  CLE_DATA);
        exp_ev(EV_CENHI, b + 17*p + 13, 40'h0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic got(input int kind, input logic [39:0] d);
        ev_t ev;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d edge=%0d data=%h, want no event",
                     kind, ecnt, d);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != kind || ev.edge_no != ecnt || ev.data !== d) begin
                n_fail++;
                $display("FAIL event: got kind=%0d edge=%0d data=%h, want kind=%0d edge=%0d data=%h",
                         kind, ecnt, d, ev.kind, ev.edge_no, ev.data);
            end
        end
    endtask

    // Monitor: sample 1 time unit after each active (falling) edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            n_chk++;
            if (bus.onfi_ale || bus.onfi_dqs_en || (bus.done && bus.timeout)) begin
                n_fail++;
                $display("FAIL pin_invariant: got ale=%b dqs_en=%b done=%b timeout=%b, want ale=0 dqs_en=0 not(done&timeout)",
                         bus.onfi_ale, bus.onfi_dqs_en, bus.done, bus.timeout);
            end
            if (prev_cen && !bus.onfi_cen) got(EV_CENLO, 40'h0);
            if (bus.onfi_cle)              got(EV_CLE, {7'b0, bus.onfi_dq_en, bus.onfi_dq_o});
            if (!prev_cen && bus.onfi_cen) got(EV_CENHI, 40'h0);
            if (bus.done)                  got(EV_DONE, {32'h0, bus.status});
            if (bus.timeout)               got(EV_TMO,  {32'h0, bus.status});
        end
        prev_cen = bus.onfi_cen;
    end

    task automatic wait_edge(input int n);
        while (ecnt < n) @(posedge clk);
    endtask

    task automatic launch(output int b);
        @(posedge clk);
        bus.start = 1'b1;
        b = ecnt + 1;
    endtask

    task automatic release_start();
        @(posedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        bus.start     = 1'b0;
        bus.onfi_dq_i = 32'h0;

        // Power-on reset values
        #1 rst_n = 1'b0;
        #2 chk("reset_vals", 64'(outs()), 64'(RST_OUTS));
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // A: immediate RDY (E0h)
        bus.onfi_dq_i = 32'h0000_00E0;
        launch(b);
        exp_poll(b, 0);
        exp_ev(EV_DONE, b + 13, 40'hE0);
        release_start();
        wait_edge(b + 20);
        chk("A_busy", 64'(bus.busy), 64'd0);
        chk("A_status", 64'(bus.status), 64'hE0);
        chk("A_drained", 64'(exp_q.size()), 64'd0);

        // B: two busy polls (80h), then ready (C0h)
        bus.onfi_dq_i = 32'h0000_0080;
        launch(b);
        exp_poll(b, 0);
        exp_poll(b, 1);
        exp_poll(b, 2);
        exp_ev(EV_DONE, b + 47, 40'hC0);
        release_start();
        wait_edge(b + 20);
        chk("B_busy_mid", 64'(bus.busy), 64'd1);
        chk("B_status_mid", 64'(bus.status), 64'h80);
        wait_edge(b + 35);
        bus.onfi_dq_i = 32'h0000_00C0;
        wait_edge(b + 55);
        chk("B_busy", 64'(bus.busy), 64'd0);
        chk("B_status", 64'(bus.status), 64'hC0);
        chk("B_drained", 64'(exp_q.size()), 64'd0);

        // C: start re-pulsed at E5 and on the done edge E13 is ignored
        bus.onfi_dq_i = 32'h0000_00E0;
        launch(b);
        exp_poll(b, 0);
        exp_ev(EV_DONE, b + 13, 40'hE0);
        release_start();
        wait_edge(b + 4);
        bus.start = 1'b1;
        release_start();
        wait_edge(b + 12);
        bus.start = 1'b1;
        release_start();
        wait_edge(b + 35);
        chk("C_busy", 64'(bus.busy), 64'd0);
        chk("C_drained", 64'(exp_q.size()), 64'd0);

        // D: reset asserted mid-WHR
        launch(b);
        exp_ev(EV_CENLO, b,     40'h0);
        exp_ev(EV_CLE,   b + 1, CLE_DATA);
        release_start();
        wait_edge(b + 5);
        chk("D_busy_pre", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("D_reset_vals", 64'(outs()), 64'(RST_OUTS));
        @(posedge clk);
        rst_n = 1'b1;
        wait_edge(b + 10);
        chk("D_busy_post", 64'(bus.busy), 64'd0);
        chk("D_cen_post", 64'(bus.onfi_cen), 64'd1);
        chk("D_drained", 64'(exp_q.size()), 64'd0);

        // E: never ready (00h)
        bus.onfi_dq_i = 32'h0;
        launch(b);
`ifdef ONFI_POLL_TIMEOUT_EN
        for (int p = 0; p < 3; p++) exp_poll(b, p);
        exp_ev(EV_TMO, b + 47, 40'h00);
        release_start();
        wait_edge(b + 46);
        chk("E_busy_mid", 64'(bus.busy), 64'd1);
        wait_edge(b + 50);
        chk("E_busy", 64'(bus.busy), 64'd0);
        chk("E_drained", 64'(exp_q.size()), 64'd0);
`else
        for (int p = 0; p < 100; p++) exp_poll(b, p);
        release_start();
        wait_edge(b + 1699);
        chk("E_busy", 64'(bus.busy), 64'd1);
        chk("E_timeout", 64'(bus.timeout), 64'd0);
        chk("E_drained", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(posedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
